mem_bus_arbiter: RTL and testbench

Shares the single p18240 memory port between two masters: the CPU datapath (requester 0) and an auxiliary master such as a debug loader or DMA engine (requester 1). It arbitrates with CPU-first priority plus an anti-starvation limit, latches the winner's command, and sequences a fixed-length access. It drives the memorySystem strobes (re_L/we_L, address, write data) and returns read data with a one-cycle done pulse. It sits between the controlpath/datapath and memorySystem.

---
 rtl/mem_bus_arbiter_pkg.sv | 17 +
 rtl/mem_bus_arbiter.sv | 115 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default parameters for the two-master memory port arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_ACCESS
  } arbState_t;

  typedef enum logic {
    M_CPU,
    M_AUX
  } master_t;

  localparam int ACC_CYCLES_DEF = 1;
  localparam int MAX_WAIT_DEF   = 4;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between the CPU datapath and an auxiliary
// master. The CPU has priority, but an anti-starvation streak counter lets
// aux win once after MAX_WAIT consecutive contended CPU wins. The winner's
// command is latched, and a fixed-length access is then sequenced.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ACC_CYCLES = ACC_CYCLES_DEF,
  parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [15:0] aux_addr,
  input  logic [15:0] aux_wdata,
  output logic        cpu_gnt,
  output logic        aux_gnt,
  output logic        cpu_done,
  output logic        aux_done,
  output logic [15:0] rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_re_L,
  output logic        mem_we_L,
  input  logic [15:0] mem_rdata,
  output logic        owner
);

  localparam int CNT_W    = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam int STREAK_W = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;
  localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(ACC_CYCLES - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WAIT);

  arbState_t           state;
  master_t             win;
  logic                lat_we;
  logic [CNT_W-1:0]    cnt;
  logic [STREAK_W-1:0] streak;
  logic                pick_aux;

  // Aux wins when it is alone, or when the CPU has starved it MAX_WAIT times
  always_comb begin
    pick_aux = aux_req && (!cpu_req || (streak == STREAK_MAX));
  end

  // Arbitration FSM: latch the winner's command, count the access, pulse done
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      win       <= M_CPU;
      lat_we    <= 1'b0;
      cnt       <= '0;
      streak    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      cpu_done  <= 1'b0;
      aux_done  <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      aux_done <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (cpu_req || aux_req) begin
            if (pick_aux) begin
              win       <= M_AUX;
              lat_we    <= aux_we;
              mem_addr  <= aux_addr;
              mem_wdata <= aux_wdata;
              streak    <= '0;
            end else begin
              win       <= M_CPU;
              lat_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              if (aux_req) begin
                if (streak != STREAK_MAX) streak <= streak + 1'b1;
              end else begin
                streak <= '0;
              end
            end
            cnt   <= CNT_LOAD;
            state <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (cnt == '0) begin
            if (!lat_we) rdata <= mem_rdata;
            if (win == M_CPU) cpu_done <= 1'b1;
            else              aux_done <= 1'b1;
            state <= ARB_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Grants, strobes and owner are decoded purely from registered state
  always_comb begin
    cpu_gnt  = (state == ARB_ACCESS) && (win == M_CPU);
    aux_gnt  = (state == ARB_ACCESS) && (win == M_AUX);
    mem_re_L = !((state == ARB_ACCESS) && !lat_we);
    mem_we_L = !((state == ARB_ACCESS) &&  lat_we);
    owner    = (win == M_AUX);
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with ACC_CYCLES=2, MAX_WAIT=4.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, aux_req, aux_we;
  logic [15:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic        cpu_gnt, aux_gnt, cpu_done, aux_done;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_re_L, mem_we_L, owner;

  logic [15:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.ACC_CYCLES(2), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .cpu_gnt(cpu_gnt), .aux_gnt(aux_gnt), .cpu_done(cpu_done), .aux_done(aux_done),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re_L(mem_re_L), .mem_we_L(mem_we_L), .mem_rdata(mem_rdata), .owner(owner)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Simple memory model: combinational read, write on the clock edge while strobed
  assign mem_rdata = mem[mem_addr];
  always @(posedge clock) begin
    if (mem_we_L === 1'b0) mem[mem_addr] <= mem_wdata;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    mem[16'h0040] = 16'hBEEF;
    mem[16'h8000] = 16'h0000;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
    tick();
    tick();

    // Reset values
    check1 ("rst_re_L",  mem_re_L, 1'b1);
    check1 ("rst_we_L",  mem_we_L, 1'b1);
    check1 ("rst_cgnt",  cpu_gnt,  1'b0);
    check1 ("rst_agnt",  aux_gnt,  1'b0);
    check1 ("rst_cdone", cpu_done, 1'b0);
    check1 ("rst_owner", owner,    1'b0);
    check16("rst_rdata", rdata,    16'h0000);
    check16("rst_addr",  mem_addr, 16'h0000);
    reset = 1'b0;

    // Single CPU read of 0x0040, plus mid-access address change
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    tick();
    check1 ("rd_c1_gnt",  cpu_gnt,  1'b1);
    check1 ("rd_c1_re",   mem_re_L, 1'b0);
    check1 ("rd_c1_we",   mem_we_L, 1'b1);
    check16("rd_c1_addr", mem_addr, 16'h0040);
    cpu_addr = 16'h1111;
    tick();
    check1 ("rd_c2_gnt",  cpu_gnt,  1'b1);
    check1 ("rd_c2_re",   mem_re_L, 1'b0);
    check16("rd_c2_addr", mem_addr, 16'h0040);
    check1 ("rd_c2_done", cpu_done, 1'b0);
    cpu_req = 1'b0;
    tick();
    check1 ("rd_c3_done", cpu_done, 1'b1);
    check1 ("rd_c3_gnt",  cpu_gnt,  1'b0);
    check1 ("rd_c3_re",   mem_re_L, 1'b1);
    check16("rd_c3_data", rdata,    16'hBEEF);
    tick();
    check1 ("rd_c4_done", cpu_done, 1'b0);

    // Aux write of 0x1234 to 0x8000
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 16'h8000; aux_wdata = 16'h1234;
    tick();
    check1 ("wr_c1_gnt",   aux_gnt,   1'b1);
    check1 ("wr_c1_cgnt",  cpu_gnt,   1'b0);
    check1 ("wr_c1_we",    mem_we_L,  1'b0);
    check1 ("wr_c1_re",    mem_re_L,  1'b1);
    check16("wr_c1_addr",  mem_addr,  16'h8000);
    check16("wr_c1_wdata", mem_wdata, 16'h1234);
    check1 ("wr_c1_owner", owner,     1'b1);
    aux_req = 1'b0;
    tick();
    check1 ("wr_c2_we",    mem_we_L,  1'b0);
    check1 ("wr_c2_re",    mem_re_L,  1'b1);
    tick();
    check1 ("wr_c3_done",  aux_done,  1'b1);
    check1 ("wr_c3_we",    mem_we_L,  1'b1);
    check16("wr_c3_rdata", rdata,     16'hBEEF);

    // CPU reads back 0x8000
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8000;
    tick();
    cpu_req = 1'b0;
    tick();
    tick();
    check1 ("rb_done",  cpu_done, 1'b1);
    check16("rb_rdata", rdata,    16'h1234);

    // Contention: both hold req; expected order CPU x4, AUX, CPU
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h8000;
    for (int k = 0; k < 6; k++) begin
      logic exp_aux;
      exp_aux = (k == 4);
      tick();
      check1 ("ct_cgnt",  cpu_gnt, !exp_aux);
      check1 ("ct_agnt",  aux_gnt,  exp_aux);
      check1 ("ct_owner", owner,    exp_aux);
      tick();
      check1 ("ct_agnt2", aux_gnt,  exp_aux);
      tick();
      check1 ("ct_cdone", cpu_done, !exp_aux);
      check1 ("ct_adone", aux_done,  exp_aux);
      check16("ct_rdata", rdata, exp_aux ? 16'h1234 : 16'hBEEF);
      if (k == 5) begin
        cpu_req = 1'b0;
        aux_req = 1'b0;
      end
    end
    tick();
    check1 ("ct_idle_gnt", cpu_gnt, 1'b0);

    // Reset asserted during cycle 1 of a CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'hAAAA;
    tick();
    check1 ("rm_c1_we", mem_we_L, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check1 ("rm_we",    mem_we_L, 1'b1);
    check1 ("rm_gnt",   cpu_gnt,  1'b0);
    check16("rm_addr",  mem_addr, 16'h0000);
    check16("rm_rdata", rdata,    16'h0000);
    check16("rm_wdata", mem_wdata, 16'h0000);
    cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check1("rm_nodone", cpu_done, 1'b0);
      check1("rm_nogrant", cpu_gnt, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
